// File: rtl/toy_pkg.sv
// Shared types and constants for the toy machine's memory path.
// Requester indices name the fixed ports of the memory arbiter.
package toy_pkg;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 16;
    localparam int REQ_CORE  = 0;
    localparam int REQ_PANEL = 1;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit searching
// upward from ptr+1, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win,
    output logic             any
);
    int idx;

    // Walk from the farthest candidate down so the nearest one after ptr wins.
    always_comb begin
        win = '0;
        idx = 0;
        any = |req;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (req[idx]) win = IDX_W'(idx);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory read/write port between N_REQ
// requesters, with grant hold until handshake and bounded locking.
module mem_arbiter #(
    parameter int N_REQ    = 2,
    parameter int ADDR_W   = toy_pkg::ADDR_W,
    parameter int DATA_W   = toy_pkg::DATA_W,
    parameter int MAX_LOCK = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_REQ-1:0]              req_val_i,
    input  logic [N_REQ-1:0]              req_wen_i,
    input  logic [N_REQ-1:0]              req_lock_i,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_wdata_i,
    output logic [N_REQ-1:0]              req_rdy_o,
    output logic [DATA_W-1:0]             req_rdata_o,
    output logic                          mem_val_o,
    output logic                          mem_wen_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    input  logic                          mem_rdy_i,
    output logic [$clog2(N_REQ)-1:0]      grant_o,
    output logic                          busy_o
);
    import toy_pkg::*;

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int LOCK_W = $clog2(MAX_LOCK + 1);

    arb_state_e        state, state_nxt;
    logic [IDX_W-1:0]  grant, grant_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [IDX_W-1:0]  win;
    logic              any;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req (req_val_i),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    // ptr starts at the top index so requester 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= IDX_W'(N_REQ - 1);
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            ptr      <= ptr_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        ptr_nxt      = ptr;
        lock_cnt_nxt = lock_cnt;
        mem_val_o    = 1'b0;
        mem_wen_o    = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        req_rdy_o    = '0;
        case (state)
            IDLE: begin
                if (any) begin
                    grant_nxt    = win;
                    lock_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                mem_val_o        = req_val_i[grant];
                mem_wen_o        = req_wen_i[grant];
                mem_addr_o       = req_addr_i[grant];
                mem_wdata_o      = req_wdata_i[grant];
                req_rdy_o[grant] = mem_rdy_i;
                if (mem_rdy_i) begin
                    ptr_nxt = grant;
                    // Lock is honoured for at most MAX_LOCK back-to-back transactions.
                    if (req_lock_i[grant] && (int'(lock_cnt) < MAX_LOCK - 1)) begin
                        lock_cnt_nxt = lock_cnt + LOCK_W'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (!req_val_i[grant]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_rdata_o = mem_rdata_i;
    assign grant_o     = grant;
    assign busy_o      = (state == GRANT);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester drivers, a latency-programmable
// memory model, and a scoreboard monitor checking every completed transaction.
module tb_mem_arbiter;
    import toy_pkg::*;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         req_val, req_wen, req_lock, req_rdy;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_wdata;
    logic [DW-1:0]        req_rdata;
    logic                 mem_val, mem_wen, mem_rdy;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata, mem_rdata;
    logic [0:0]           grant;
    logic                 busy;

    logic          drv_val[N];
    logic          drv_wen[N];
    logic          drv_lock[N];
    logic [AW-1:0] drv_addr[N];
    logic [DW-1:0] drv_wdata[N];

    assign req_val   = {drv_val[1], drv_val[0]};
    assign req_wen   = {drv_wen[1], drv_wen[0]};
    assign req_lock  = {drv_lock[1], drv_lock[0]};
    assign req_addr  = {drv_addr[1], drv_addr[0]};
    assign req_wdata = {drv_wdata[1], drv_wdata[0]};

    mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_val_i   (req_val),
        .req_wen_i   (req_wen),
        .req_lock_i  (req_lock),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_rdy_o   (req_rdy),
        .req_rdata_o (req_rdata),
        .mem_val_o   (mem_val),
        .mem_wen_o   (mem_wen),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_rdy_i   (mem_rdy),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    // Memory model: rdy pulses lat cycles after val is first seen; word i resets to i^0xA500.
    logic [DW-1:0] mem[256];
    int lat = 1;
    int cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdy   <= 1'b0;
            cnt       <= 0;
            mem_rdata <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i) ^ 16'hA500;
            mem[8'h10] <= 16'hBEEF;
        end else begin
            mem_rdy <= 1'b0;
            if (mem_val && !mem_rdy) begin
                if (cnt >= lat - 1) begin
                    mem_rdy   <= 1'b1;
                    cnt       <= 0;
                    mem_rdata <= mem[mem_addr];
                    if (mem_wen) mem[mem_addr] <= mem_wdata;
                end else begin
                    cnt <= cnt + 1;
                end
            end else begin
                cnt <= 0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        bit         wen;
        logic [7:0] addr;
        logic [15:0] data;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int last_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_x(input int idx, input bit wen, input logic [7:0] a,
                            input logic [15:0] d, input int gap);
        exp_t e;
        e.idx = idx; e.wen = wen; e.addr = a; e.data = d; e.gap = gap;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every completion is compared against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && req_rdy != '0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rdy: got %b want none", req_rdy);
                end else begin
                    e = sb.pop_front();
                    check("rdy_onehot", 32'(req_rdy), 32'(1) << e.idx);
                    check("addr", 32'(mem_addr), 32'(e.addr));
                    check("wen", 32'(mem_wen), 32'(e.wen));
                    if (e.wen) check("wdata", 32'(mem_wdata), 32'(e.data));
                    else       check("rdata", 32'(req_rdata), 32'(e.data));
                    if (e.gap >= 0) check("gap", 32'(cyc - last_cyc), 32'(e.gap));
                end
                last_cyc = cyc;
            end
        end
    end

    // One transaction; with last=0 val stays high for a back-to-back follow-up.
    task automatic xact(input int r, input bit wen, input logic [7:0] a,
                        input logic [15:0] d, input bit lk, input bit last);
        int n;
        drv_val[r] = 1'b1; drv_wen[r] = wen; drv_addr[r] = a;
        drv_wdata[r] = d;  drv_lock[r] = lk;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (req_rdy[r]) break;
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL timeout_req%0d: got no rdy want rdy", r);
                break;
            end
        end
        @(posedge clk); #1;
        if (last) begin drv_val[r] = 1'b0; drv_lock[r] = 1'b0; end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_val"},   32'(mem_val),   0);
        check({tag, "_mem_wen"},   32'(mem_wen),   0);
        check({tag, "_mem_addr"},  32'(mem_addr),  0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_req_rdy"},   32'(req_rdy),   0);
        check({tag, "_grant"},     32'(grant),     0);
        check({tag, "_busy"},      32'(busy),      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            drv_val[i] = 1'b0; drv_wen[i] = 1'b0; drv_lock[i] = 1'b0;
            drv_addr[i] = '0;  drv_wdata[i] = '0;
        end
        // Reset state, even with a request pending during reset.
        drv_val[REQ_CORE] = 1'b1;
        drv_addr[REQ_CORE] = 8'h77;
        #22;
        check_idle_outputs("rst");
        check("rst_rdata", 32'(req_rdata), 32'(mem_rdata));
        drv_val[REQ_CORE] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read, latency 2.
        lat = 2;
        expect_x(REQ_CORE, 1'b0, 8'h10, 16'hBEEF, -1);
        fork
            xact(REQ_CORE, 1'b0, 8'h10, 16'h0, 1'b0, 1'b1);
            begin
                @(negedge clk); check("lat_c0_mem_val", 32'(mem_val), 0);
                @(negedge clk); check("lat_c1_mem_val", 32'(mem_val), 1);
                check("lat_c1_busy", 32'(busy), 1);
                check("lat_c1_addr", 32'(mem_addr), 32'h10);
                @(negedge clk); check("lat_c2_rdy", 32'(req_rdy), 0);
                @(negedge clk); check("lat_c3_rdy", 32'(req_rdy), 1);
            end
        join
        check("read_busy_after", 32'(busy), 0);

        // Contention after reset: alternating 0,1,0,1 with one bubble each.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        expect_x(0, 1'b0, 8'h30, 16'hA530, -1);
        expect_x(1, 1'b0, 8'h40, 16'hA540, 3);
        expect_x(0, 1'b0, 8'h31, 16'hA531, 3);
        expect_x(1, 1'b0, 8'h41, 16'hA541, 3);
        fork
            begin
                xact(0, 1'b0, 8'h30, 16'h0, 1'b0, 1'b0);
                xact(0, 1'b0, 8'h31, 16'h0, 1'b0, 1'b1);
            end
            begin
                xact(1, 1'b0, 8'h40, 16'h0, 1'b0, 1'b0);
                xact(1, 1'b0, 8'h41, 16'h0, 1'b0, 1'b1);
            end
        join

        // Lock limit: 4 locked writes, then req0, then remaining 2 writes.
        expect_x(1, 1'b1, 8'h20, 16'h0100, -1);
        expect_x(1, 1'b1, 8'h21, 16'h0101, 2);
        expect_x(1, 1'b1, 8'h22, 16'h0102, 2);
        expect_x(1, 1'b1, 8'h23, 16'h0103, 2);
        expect_x(0, 1'b0, 8'h40, 16'hA540, 3);
        expect_x(1, 1'b1, 8'h24, 16'h0104, 3);
        expect_x(1, 1'b1, 8'h25, 16'h0105, 2);
        fork
            begin
                for (int i = 0; i < 6; i++)
                    xact(1, 1'b1, 8'(8'h20 + i), 16'(16'h0100 + i), (i != 5), (i == 5));
            end
            begin
                @(posedge clk); #1;
                xact(0, 1'b0, 8'h40, 16'h0, 1'b0, 1'b1);
            end
        join
        expect_x(0, 1'b0, 8'h22, 16'h0102, -1);
        expect_x(0, 1'b0, 8'h25, 16'h0105, 3);
        xact(0, 1'b0, 8'h22, 16'h0, 1'b0, 1'b0);
        xact(0, 1'b0, 8'h25, 16'h0, 1'b0, 1'b1);

        // Write passthrough held stable until rdy, latency 3.
        lat = 3;
        expect_x(1, 1'b1, 8'hFF, 16'h1234, -1);
        fork
            xact(1, 1'b1, 8'hFF, 16'h1234, 1'b0, 1'b1);
            begin
                @(negedge clk); check("wr_c0_busy", 32'(busy), 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("wr_hold_val",   32'(mem_val),   1);
                    check("wr_hold_wen",   32'(mem_wen),   1);
                    check("wr_hold_addr",  32'(mem_addr),  32'hFF);
                    check("wr_hold_wdata", 32'(mem_wdata), 32'h1234);
                    check("wr_hold_rdy",   32'(req_rdy),   0);
                end
            end
        join

        // Abort: req0 drops val mid-grant; ptr unchanged so req0 wins the next tie.
        drv_val[0] = 1'b1; drv_wen[0] = 1'b0; drv_addr[0] = 8'h55;
        @(posedge clk); #1;
        check("abort_mem_val", 32'(mem_val), 1);
        check("abort_grant", 32'(grant), 0);
        drv_val[0] = 1'b0;
        @(negedge clk);
        check("abort_still_busy", 32'(busy), 1);
        check("abort_val_low", 32'(mem_val), 0);
        @(posedge clk); #1;
        check("abort_idle", 32'(busy), 0);
        lat = 1;
        expect_x(0, 1'b0, 8'h30, 16'hA530, -1);
        expect_x(1, 1'b0, 8'h31, 16'hA531, 3);
        fork
            xact(0, 1'b0, 8'h30, 16'h0, 1'b0, 1'b1);
            xact(1, 1'b0, 8'h31, 16'h0, 1'b0, 1'b1);
        join

        // Reset mid-transaction: outputs drop at once, then req0 wins a tie.
        lat = 3;
        drv_val[1] = 1'b1; drv_wen[1] = 1'b1; drv_addr[1] = 8'h50; drv_wdata[1] = 16'h9999;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 1);
        check("mid_grant", 32'(grant), 1);
        check("mid_mem_val", 32'(mem_val), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        drv_val[1] = 1'b0; drv_wen[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = 1;
        expect_x(0, 1'b0, 8'h40, 16'hA540, -1);
        expect_x(1, 1'b0, 8'h41, 16'hA541, 3);
        fork
            xact(0, 1'b0, 8'h40, 16'h0, 1'b0, 1'b1);
            xact(1, 1'b0, 8'h41, 16'h0, 1'b0, 1'b1);
        join

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
